// File: rtl/icache_port_arbiter_pkg.sv
// Shared core definitions for the instruction-memory port arbiter:
// default widths and the fetch-response entry layout.
package icache_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [ADDR_W_DEF-1:0] addr;
  } rsp_entry_t;

endpackage

// File: rtl/icache_port_arbiter_rsp_fifo2.sv
// Two-entry valid/ready FIFO holding fetch responses; clr_i empties it
// at the next edge and takes priority over push and pop.
module rsp_fifo2
  import icache_port_arbiter_pkg::*;
#(
  parameter type T = rsp_entry_t
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic in_valid_i,
  input  T     in_data_i,
  output logic in_ready_o,
  output logic out_valid_o,
  output T     out_data_o,
  input  logic out_ready_i
);

  T           mem_q [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] cnt_q, cnt_d;
  logic       push, pop;

  assign in_ready_o  = (cnt_q != 2'd2);
  assign out_valid_o = (cnt_q != 2'd0);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;
  // Idle output is forced to zero so the response bus reads 0 after reset.
  assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (clr_i) begin
      cnt_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

endmodule

// File: rtl/icache_port_arbiter.sv
// Arbitrates a single-port synchronous instruction memory between the fetch
// read channel and the program-loader write channel, with starvation relief.
module icache_port_arbiter
  import icache_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req_valid,
  input  logic [ADDR_W-1:0] fetch_req_addr,
  output logic              fetch_req_ready,
  output logic              fetch_rsp_valid,
  output logic [DATA_W-1:0] fetch_rsp_data,
  output logic [ADDR_W-1:0] fetch_rsp_addr,
  input  logic              fetch_rsp_ready,
  input  logic              fetch_flush,
  input  logic              load_req_valid,
  input  logic [ADDR_W-1:0] load_req_addr,
  input  logic [DATA_W-1:0] load_req_data,
  output logic              load_req_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  // Same layout as rsp_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_addr_q, inflight_addr_d;
  logic [SW-1:0]     starve_q, starve_d;

  logic   fifo_in_ready, fifo_out_valid;
  entry_t fifo_in, fifo_out;
  logic   deq, enq, space_ok, starve_max, load_pri;
  logic   fetch_gnt, load_gnt;
  logic [2:0] pending;

  assign starve_max = (starve_q == SW'(STARVE_MAX));
  assign load_pri   = load_req_valid & starve_max;
  assign deq        = fifo_out_valid & fetch_rsp_ready;

  // Entries held (0..2, from the FIFO flags) plus the read still in flight,
  // minus what leaves this cycle; a new read needs this below 2 to be sure
  // of a slot when its data lands.
  assign pending  = {2'b0, fifo_out_valid} + {2'b0, ~fifo_in_ready}
                  + {2'b0, inflight_q} - {2'b0, deq};
  assign space_ok = (pending < 3'd2);

  assign fetch_req_ready = ~reset & ~fetch_flush & space_ok & ~load_pri;
  assign fetch_gnt       = fetch_req_valid & fetch_req_ready;
  assign load_req_ready  = ~reset & ~fetch_gnt;
  assign load_gnt        = load_req_valid & load_req_ready;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (fetch_gnt) begin
      mem_en   = 1'b1;
      mem_addr = fetch_req_addr;
    end else if (load_gnt) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = load_req_addr;
      mem_wdata = load_req_data;
    end
  end

  always_comb begin
    inflight_d      = fetch_gnt;
    inflight_addr_d = fetch_gnt ? fetch_req_addr : inflight_addr_q;
    starve_d        = starve_q;
    if (!load_req_valid || load_gnt)
      starve_d = '0;
    else if (fetch_gnt && !starve_max)
      starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      starve_q        <= '0;
    end else begin
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
      starve_q        <= starve_d;
    end
  end

  // A flush drops the read whose data arrives this cycle as well as the queue.
  assign enq          = inflight_q & ~fetch_flush;
  assign fifo_in.data = mem_rdata;
  assign fifo_in.addr = inflight_addr_q;

  rsp_fifo2 #(.T(entry_t)) u_rsp_fifo (
    .clk         (clk),
    .rst         (reset),
    .clr_i       (fetch_flush),
    .in_valid_i  (enq),
    .in_data_i   (fifo_in),
    .in_ready_o  (fifo_in_ready),
    .out_valid_o (fifo_out_valid),
    .out_data_o  (fifo_out),
    .out_ready_i (fetch_rsp_ready)
  );

  assign fetch_rsp_valid = fifo_out_valid;
  assign fetch_rsp_data  = fifo_out.data;
  assign fetch_rsp_addr  = fifo_out.addr;

endmodule

// File: doc/icache_port_arbiter.md
ICACHE_PORT_ARBITER -- requirements
Module: icache_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, instruction-memory byte address width.
REQ-002 SHALL have parameter DATA_W, default 32, instruction word width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, maximum consecutive fetch grants while the loader waits.
REQ-004 SHALL have clk  in  1  single clock; all state on its rising edge.
REQ-005 SHALL have reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have fetch_req_valid  in  1, fetch_req_addr  in  ADDR_W, fetch_req_ready  out  1  fetch read request channel.
REQ-007 SHALL have fetch_rsp_valid  out  1, fetch_rsp_data  out  DATA_W, fetch_rsp_addr  out  ADDR_W, fetch_rsp_ready  in  1  fetch response channel.
REQ-008 SHALL have fetch_flush  in  1  branch redirect; discards all fetch reads not yet consumed.
REQ-009 SHALL have load_req_valid  in  1, load_req_addr  in  ADDR_W, load_req_data  in  DATA_W, load_req_ready  out  1  program-loader write channel.
REQ-010 SHALL have mem_en  out  1, mem_we  out  1, mem_addr  out  ADDR_W, mem_wdata  out  DATA_W, mem_rdata  in  DATA_W  single-port synchronous memory; read data valid one cycle after mem_en with mem_we low.

Function
REQ-011 SHALL transfer on a channel only in a cycle where valid and ready are both high.
REQ-012 SHALL issue at most one memory access per cycle: a granted fetch sets mem_en=1, mem_we=0; a granted load sets mem_en=1, mem_we=1, mem_wdata=load_req_data.
REQ-013 SHALL grant fetch over load by default.
REQ-014 SHALL keep a starve counter (0..STARVE_MAX), incremented per fetch grant while load_req_valid is high, cleared on any load grant or when load_req_valid is low.
REQ-015 SHALL grant load instead of fetch in any cycle where the starve counter equals STARVE_MAX.
REQ-016 SHALL assert fetch_req_ready only when fetch_flush is low, fetch wins arbitration, and (buffer occupancy + in-flight reads - response dequeued this cycle) is less than 2.
REQ-017 SHALL hold a 2-entry response FIFO of {data, addr}; read issued in cycle t is written from mem_rdata at end of t+1; fetch_rsp_valid is high from t+2 at the earliest.
REQ-018 SHALL sustain one fetch per cycle when fetch_rsp_ready is held high (2-cycle issue-to-response latency).
REQ-019 SHALL present responses in issue order; fetch_rsp_data/addr stable while fetch_rsp_valid is high and fetch_rsp_ready is low.
REQ-020 SHALL, when fetch_flush is high, empty the FIFO at the clock edge, mark any read in flight as discarded (never enqueued), and accept no fetch in that cycle; fetch_rsp_valid is low the following cycle.
REQ-021 SHALL treat flush and a response handshake in the same cycle as a flush (entry dropped, handshake ignored).
REQ-022 SHALL assert load_req_ready only in cycles where load wins arbitration; load may be granted while fetch reads are in flight.
REQ-023 SHALL drive mem_en=0 and mem_addr/mem_wdata to 0 in cycles with no grant.

Reset
REQ-024 SHALL on reset clear FIFO, in-flight flag and starve counter, immediately driving fetch_req_ready, fetch_rsp_valid, load_req_ready, mem_en and mem_we to 0 and fetch_rsp_data/addr to 0.
REQ-025 SHALL, on reset asserted mid-operation, discard any in-flight read; no response is produced after reset release for reads issued before it.

Structure
REQ-026 SHALL place ADDR_W, DATA_W defaults and the response-entry struct {data, addr} in the shared core package.
REQ-027 SHALL implement the response buffer as one sub-module, rsp_fifo2 (2-entry, valid/ready, synchronous clear).

Verification
REQ-028 SHALL cover: back-to-back fetch addr 0x000,0x004,0x008, rsp_ready=1 -> rsp addrs 0x000,0x004,0x008 on consecutive cycles, first two cycles after first issue.
REQ-029 SHALL cover: rsp_ready=0 with two fetches accepted -> third fetch_req_ready=0 until one response consumed; data order preserved.
REQ-030 SHALL cover: fetch and load both valid continuously, STARVE_MAX=4 -> 4 fetch grants, then 1 load grant (mem_we=1), repeating.
REQ-031 SHALL cover: flush in cycle after read to 0x010 issued, FIFO holding 0x00C -> fetch_rsp_valid low next cycle; 0x010 never presented.
REQ-032 SHALL cover: load write 0xDEADBEEF to 0x020, then fetch 0x020 -> fetch_rsp_data=0xDEADBEEF.
REQ-033 SHALL cover: reset asserted asynchronously with a read in flight -> all outputs 0 before next edge; no response after release.
